// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes, mux selects and the control strobe bundle.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SRCB_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_BOFF = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [SRCB_W-1:0]  alu_src_b;
    logic               ext_zero;
    logic [PCSRC_W-1:0] pc_source;
    logic [ALU_W-1:0]   alu_ctrl;
    logic               illegal;
  } ctrl_s;

  // State following DECODE; FETCH means the opcode is not supported.
  function automatic state_e decode_next(input logic [OP_W-1:0] op, input logic bne_en);
    state_e nxt;
    case (op)
      OP_RTYPE:                nxt = S_R_EXEC;
      OP_LW, OP_SW:            nxt = S_MEM_ADDR;
      OP_BEQ:                  nxt = S_BRANCH;
      OP_BNE:                  nxt = bne_en ? S_BRANCH : S_FETCH;
      OP_J:                    nxt = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
      default:                 nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decoder: selects the ALU function from the current state,
// opcode and funct, and flags unsupported R-type funct codes.
module alu_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  state_e               state_i,
  input  logic [OP_W-1:0]      opcode_i,
  input  logic [FUNCT_W-1:0]   funct_i,
  output logic [ALU_W-1:0]     alu_ctrl_o,
  output logic                 funct_illegal_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (state_i)
      S_BRANCH: alu_ctrl_o = ALU_SUB;
      S_R_EXEC: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      S_I_EXEC: begin
        case (opcode_i)
          OP_ANDI: alu_ctrl_o = ALU_AND;
          OP_ORI:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with per-state control strobes and memory stalls.
// Define MC_CTRL_BNE_EN to decode bne (opcode 000101) as a branch on !zero.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SRCB_W-1:0]   alu_src_b,
  output logic                ext_zero,
  output logic [PCSRC_W-1:0]  pc_source,
  output logic [ALU_W-1:0]    alu_ctrl,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

`ifdef MC_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  state_e           dec_target;
  logic             bne_q, bne_d;
  logic [ALU_W-1:0] alu_op;
  logic             funct_illegal;
  ctrl_s            ctrl_c;

  assign dec_target = decode_next(opcode, BNE_EN);

  alu_ctrl_dec u_alu_ctrl_dec (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .alu_ctrl_o      (alu_op),
    .funct_illegal_o (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_e'(RESET_STATE);
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
    end
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dec_target;
        bne_d   = BNE_EN && (opcode == OP_BNE);
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = funct_illegal ? S_FETCH : S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state strobes; reset overrides everything to the idle pattern.
  always_comb begin
    ctrl_c          = '0;
    ctrl_c.alu_ctrl = ALU_ADD;
    if (!rst) begin
      ctrl_c.alu_ctrl = alu_op;
      case (state_q)
        S_FETCH: begin
          ctrl_c.mem_read  = 1'b1;
          ctrl_c.alu_src_b = SRCB_FOUR;
          ctrl_c.ir_write  = mem_ready;
          ctrl_c.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl_c.alu_src_b = SRCB_BOFF;
          ctrl_c.illegal   = (dec_target == S_FETCH);
        end
        S_MEM_ADDR: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          ctrl_c.mem_read = 1'b1;
          ctrl_c.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctrl_c.mem_write = 1'b1;
          ctrl_c.i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_REG;
          ctrl_c.illegal   = funct_illegal;
        end
        S_R_WB: begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          // beq leaves the zero test to the datapath; bne pre-qualifies with !zero
          ctrl_c.alu_src_a     = 1'b1;
          ctrl_c.alu_src_b     = SRCB_REG;
          ctrl_c.pc_source     = PCSRC_ALUOUT;
          ctrl_c.pc_write_cond = ~(bne_q & zero);
        end
        S_JUMP: begin
          ctrl_c.pc_write  = 1'b1;
          ctrl_c.pc_source = PCSRC_JUMP;
        end
        S_I_EXEC: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_IMM;
          ctrl_c.ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        end
        S_I_WB: ctrl_c.reg_write = 1'b1;
        default: ctrl_c.pc_source = PCSRC_ALU;
      endcase
    end
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign i_or_d        = ctrl_c.i_or_d;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_dst       = ctrl_c.reg_dst;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign ext_zero      = ctrl_c.ext_zero;
  assign pc_source     = ctrl_c.pc_source;
  assign alu_ctrl      = ctrl_c.alu_ctrl;
  assign illegal       = ctrl_c.illegal;
  assign state         = rst ? STATE_W'(0) : STATE_W'(state_q);

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control FSM for the 32-bit MIPS datapath. It sequences the shared ALU, which contains the bitwise AND/OR slices, the adder/subtractor and SLT, together with the register file, IR, PC and unified memory port. It decodes opcode/funct and produces Moore-style per-state control strobes. It stalls on a memory ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); must not be changed in normal builds.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition met
i_or_d  out  1  0 = PC address, 1 = ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  1 = write-back from MDR
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
ext_zero  out  1  1 = zero-extend imm (andi/ori)
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
illegal  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state (debug)

Behaviour:
- Reset: synchronous and active-high. A rising clk edge with rst=1 sets state to FETCH. While rst=1, every strobe output (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal) is forced to 0. All mux selects are 0, alu_ctrl is 010 and state reads 0.
- Reset mid-instruction: the instruction is abandoned and no partial write occurs in the reset cycle.
- States:
  - FETCH(0)
  - DECODE(1)
  - MEM_ADDR(2)
  - MEM_RD(3)
  - MEM_WB(4)
  - MEM_WR(5)
  - R_EXEC(6)
  - R_WB(7)
  - BRANCH(8)
  - JUMP(9)
  - I_EXEC(10)
  - I_WB(11)
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_source=00.
  - ir_write and pc_write assert only in the cycle where mem_ready=1; that cycle advances to DECODE. Otherwise the FSM holds in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001100 or 001101 -> I_EXEC
  - anything else -> FETCH, with illegal=1 for that cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct:
  - 100000 -> ADD
  - 100010 -> SUB
  - 100100 -> AND
  - 100101 -> OR
  - 101010 -> SLT
  - other funct -> illegal pulse, next state FETCH, no write-back.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, then FETCH. The PC loads only if zero=1.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - addi -> ADD, ext_zero=0.
  - andi -> AND, ext_zero=1.
  - ori -> OR, ext_zero=1.
  - Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- Latency with mem_ready tied to 1:
  - lw = 5 cycles.
  - sw, R-type and I-type = 4 cycles.
  - beq and j = 3 cycles.
  - Each wait cycle on a memory state adds 1.
- mem_read and mem_write are never both 1 in the same cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Optional Feature:
MC_CTRL_BNE_EN:
- Defined: opcode 000101 (bne) decodes to BRANCH with an internal bne flag latched in DECODE. In BRANCH, pc_write_cond is qualified by !zero instead of zero; the control unit outputs pc_write_cond&~zero so the datapath stays unchanged.
- Undefined: 000101 is illegal (pulse, then FETCH).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI
  - funct constants
  - alu_ctrl codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
- One combinational sub-module, alu_ctrl_dec, maps (state, opcode, funct) to {alu_ctrl, funct_illegal}.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4 over 5 cycles. reg_write=1 and mem_to_reg=1 only in cycle 5, then FETCH.
- sw with mem_ready low 2 cycles in MEM_WR -> mem_write held 3 cycles with i_or_d=1, no reg_write, FETCH after the ready cycle.
- beq with zero=1 and with zero=0 -> pc_write_cond=1, pc_source=01, alu_ctrl=110 in BRANCH both times. pc_write=0 throughout BRANCH.
- R-type funct 100100 -> alu_ctrl=000 in R_EXEC. R_WB has reg_write=1, reg_dst=1. Funct 111111 -> illegal pulse, no reg_write.
- Opcode 111111 -> illegal=1 in DECODE, FETCH next. With MC_CTRL_BNE_EN, 000101 instead reaches BRANCH.
- rst asserted in MEM_RD -> next cycle state=0 with all strobes 0. After release, FETCH resumes with mem_read=1.
